dataproc_mmio_engine: RTL and testbench

Parametrised memory-mapped pixel-processing peripheral on the rvsoc native memory bus (mem_valid/mem_ready handshake). It is the next-generation data processor:
- CPU pushes pixels into an input FIFO.
- A one-stage engine applies a selectable operation (pass, invert, threshold, saturating offset).
- Results land in an output FIFO the CPU pops.
- Block adds status flags, sticky overflow/underflow, a processed-pixel counter and a soft clear.

---
 rtl/dataproc_mmio_engine_pkg.sv | 43 ++++
 rtl/dataproc_mmio_engine_fifo.sv | 82 ++++++++
 rtl/dataproc_mmio_engine.sv | 238 +++++++++++++++++++++++
 tb/tb_dataproc_mmio_engine.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dataproc_mmio_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dataproc_mmio_engine_pkg
// Description : Shared definitions for the pixel-processing MMIO engine:
//               register offsets, operation modes, CTRL/STATUS bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package dataproc_mmio_engine_pkg;

    // Register offsets relative to BASE_ADDR
    localparam logic [31:0] c_off_ctrl   = 32'h00;
    localparam logic [31:0] c_off_status = 32'h04;
    localparam logic [31:0] c_off_pixcnt = 32'h08;
    localparam logic [31:0] c_off_in     = 32'h0C;
    localparam logic [31:0] c_off_out    = 32'h10;
    localparam logic [31:0] c_off_param  = 32'h14;

    // Pixel operation selected by CTRL[2:1]
    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_INVERT = 2'd1,
        MODE_THRESH = 2'd2,
        MODE_SATADD = 2'd3
    } mode_e;

    // CTRL bit positions
    localparam int c_ctrl_en_bit   = 0;
    localparam int c_ctrl_mode_lsb = 1;
    localparam int c_ctrl_clr_bit  = 3;

    // STATUS bit positions
    localparam int c_st_in_empty   = 0;
    localparam int c_st_in_full    = 1;
    localparam int c_st_out_empty  = 2;
    localparam int c_st_out_full   = 3;
    localparam int c_st_busy       = 4;
    localparam int c_st_ovf        = 5;
    localparam int c_st_udf        = 6;
    localparam int c_st_in_cnt_lsb = 8;
    localparam int c_st_out_cnt_lsb = 16;

endpackage : dataproc_mmio_engine_pkg
`default_nettype wire

// File: rtl/dataproc_mmio_engine_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dp_sync_fifo
// Description : Synchronous FIFO with combinational head output, occupancy
//               count and a synchronous flush that overrides push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_aw-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_cw-1:0]  count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == c_cw'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + c_aw'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + c_aw'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + c_cw'(1);
                2'b01:   count_d = count_q - c_cw'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty so it needs no reset
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule : dp_sync_fifo
`default_nettype wire

// File: rtl/dataproc_mmio_engine.sv
`default_nettype none
// ============================================================================
// Module      : dataproc_mmio_engine
// Description : Memory-mapped pixel processor. CPU pushes pixels into an
//               input FIFO, a one-stage engine transforms them and results
//               are popped from an output FIFO. Fixed one-wait-cycle bus.
// Revision    : 1.0 - initial release
// ============================================================================
module dataproc_mmio_engine
    import dataproc_mmio_engine_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0200_1000,
    parameter int          PIX_W      = 8,
    parameter int          FIFO_DEPTH = 8,
    parameter int          CNT_W      = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata
);

    localparam int c_cw = $clog2(FIFO_DEPTH) + 1;

    // Registered state
    logic              mem_ready_q, mem_ready_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              ctrl_en_q, ctrl_en_d;
    mode_e             ctrl_mode_q, ctrl_mode_d;
    logic [PIX_W-1:0]  param_q, param_d;
    logic [CNT_W-1:0]  pixcnt_q, pixcnt_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              stage_valid_q, stage_valid_d;
    logic [PIX_W-1:0]  stage_data_q, stage_data_d;

    // FIFO interface
    logic              in_full, in_empty, out_full, out_empty;
    logic [c_cw-1:0]   in_count, out_count;
    logic [PIX_W-1:0]  in_dout, out_dout;
    logic              in_push, out_pop;

    // Decode
    logic [31:0]       addr_off;
    logic              sel, accept, is_wr;
    logic              wr_ctrl, wr_status, wr_pixcnt, wr_in, wr_param, rd_out;
    logic              clear;
    logic [c_cw:0]     out_occ;
    logic              eng_adv;
    logic [PIX_W-1:0]  eng_result;
    logic [PIX_W:0]    sat_sum;
    logic [31:0]       status_word;
    logic [31:0]       rdata_mux;

    assign addr_off = mem_addr - BASE_ADDR;
    assign sel      = mem_valid && (mem_addr >= BASE_ADDR) &&
                      (addr_off <= c_off_param) && (mem_addr[1:0] == 2'b00);
    assign accept   = sel && !mem_ready_q;
    assign is_wr    = |mem_wstrb;

    assign wr_ctrl   = accept &&  is_wr && (addr_off == c_off_ctrl);
    assign wr_status = accept &&  is_wr && (addr_off == c_off_status);
    assign wr_pixcnt = accept &&  is_wr && (addr_off == c_off_pixcnt);
    assign wr_in     = accept &&  is_wr && (addr_off == c_off_in);
    assign wr_param  = accept &&  is_wr && (addr_off == c_off_param);
    assign rd_out    = accept && !is_wr && (addr_off == c_off_out);
    assign clear     = wr_ctrl && mem_wdata[c_ctrl_clr_bit];

    assign in_push = wr_in && !in_full;
    assign out_pop = rd_out && !out_empty;

    // Reserve a slot for the in-flight stage so the drain can never hit a full FIFO
    assign out_occ = {1'b0, out_count} + (c_cw + 1)'(stage_valid_q);
    assign eng_adv = ctrl_en_q && !in_empty && (out_occ < (c_cw + 1)'(FIFO_DEPTH)) && !clear;

    assign sat_sum = {1'b0, in_dout} + {1'b0, param_q};

    // Pixel operation on the input FIFO head, using mode/PARAM as currently held
    always_comb begin
        eng_result = in_dout;
        case (ctrl_mode_q)
            MODE_PASS:   eng_result = in_dout;
            MODE_INVERT: eng_result = ~in_dout;
            MODE_THRESH: eng_result = (in_dout >= param_q) ? '1 : '0;
            MODE_SATADD: eng_result = sat_sum[PIX_W] ? '1 : sat_sum[PIX_W-1:0];
            default:     eng_result = in_dout;
        endcase
    end

    // STATUS word assembly
    always_comb begin
        status_word                                = '0;
        status_word[c_st_in_empty]                 = in_empty;
        status_word[c_st_in_full]                  = in_full;
        status_word[c_st_out_empty]                = out_empty;
        status_word[c_st_out_full]                 = out_full;
        status_word[c_st_busy]                     = stage_valid_q || (ctrl_en_q && !in_empty);
        status_word[c_st_ovf]                      = ovf_q;
        status_word[c_st_udf]                      = udf_q;
        status_word[c_st_in_cnt_lsb +: 8]          = 8'(in_count);
        status_word[c_st_out_cnt_lsb +: 8]         = 8'(out_count);
    end

    // Read data selection; OUT returns the head (or 0 when empty), IN reads 0
    always_comb begin
        rdata_mux = '0;
        if (!is_wr) begin
            case (addr_off)
                c_off_ctrl:   rdata_mux = 32'({ctrl_mode_q, ctrl_en_q});
                c_off_status: rdata_mux = status_word;
                c_off_pixcnt: rdata_mux = 32'(pixcnt_q);
                c_off_out:    rdata_mux = out_empty ? 32'h0 : 32'(out_dout);
                c_off_param:  rdata_mux = 32'(param_q);
                default:      rdata_mux = '0;
            endcase
        end
    end

    // Next-state for bus handshake, registers, sticky flags and the engine stage
    always_comb begin
        mem_ready_d   = 1'b0;
        mem_rdata_d   = '0;
        ctrl_en_d     = ctrl_en_q;
        ctrl_mode_d   = ctrl_mode_q;
        param_d       = param_q;
        pixcnt_d      = pixcnt_q;
        ovf_d         = ovf_q;
        udf_d         = udf_q;
        stage_valid_d = eng_adv;
        stage_data_d  = stage_data_q;

        if (accept) begin
            mem_ready_d = 1'b1;
            mem_rdata_d = rdata_mux;
        end

        if (eng_adv) begin
            stage_data_d = eng_result;
        end

        // Stage drains into the output FIFO every cycle it is valid
        if (stage_valid_q) begin
            pixcnt_d = pixcnt_q + CNT_W'(1);
        end
        if (wr_pixcnt) begin
            pixcnt_d = '0;
        end

        // W1C first so a coincident new event wins
        if (wr_status && mem_wdata[c_st_ovf]) ovf_d = 1'b0;
        if (wr_status && mem_wdata[c_st_udf]) udf_d = 1'b0;
        if (wr_in && in_full)                 ovf_d = 1'b1;
        if (rd_out && out_empty)              udf_d = 1'b1;

        if (wr_ctrl) begin
            ctrl_en_d   = mem_wdata[c_ctrl_en_bit];
            ctrl_mode_d = mode_e'(mem_wdata[c_ctrl_mode_lsb +: 2]);
        end
        if (wr_param) begin
            param_d = mem_wdata[PIX_W-1:0];
        end

        if (clear) begin
            stage_valid_d = 1'b0;
            pixcnt_d      = '0;
            ovf_d         = 1'b0;
            udf_d         = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_ready_q   <= 1'b0;
            mem_rdata_q   <= '0;
            ctrl_en_q     <= 1'b0;
            ctrl_mode_q   <= MODE_PASS;
            param_q       <= '0;
            pixcnt_q      <= '0;
            ovf_q         <= 1'b0;
            udf_q         <= 1'b0;
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
        end else begin
            mem_ready_q   <= mem_ready_d;
            mem_rdata_q   <= mem_rdata_d;
            ctrl_en_q     <= ctrl_en_d;
            ctrl_mode_q   <= ctrl_mode_d;
            param_q       <= param_d;
            pixcnt_q      <= pixcnt_d;
            ovf_q         <= ovf_d;
            udf_q         <= udf_d;
            stage_valid_q <= stage_valid_d;
            stage_data_q  <= stage_data_d;
        end
    end

    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;

    dp_sync_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_in_fifo (
        .clk    (clk),
        .resetn (resetn),
        .flush  (clear),
        .push   (in_push),
        .din    (mem_wdata[PIX_W-1:0]),
        .pop    (eng_adv),
        .dout   (in_dout),
        .full   (in_full),
        .empty  (in_empty),
        .count  (in_count)
    );

    dp_sync_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk    (clk),
        .resetn (resetn),
        .flush  (clear),
        .push   (stage_valid_q),
        .din    (stage_data_q),
        .pop    (out_pop),
        .dout   (out_dout),
        .full   (out_full),
        .empty  (out_empty),
        .count  (out_count)
    );

endmodule : dataproc_mmio_engine
`default_nettype wire

// File: tb/tb_dataproc_mmio_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_dataproc_mmio_engine
// Description : Self-checking bench for dataproc_mmio_engine with a pixel
//               scoreboard queue and per-feature test tasks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dataproc_mmio_engine;

    localparam logic [31:0] BASE = 32'h0200_1000;
    localparam logic [31:0] A_CTRL   = BASE + 32'h00;
    localparam logic [31:0] A_STATUS = BASE + 32'h04;
    localparam logic [31:0] A_PIXCNT = BASE + 32'h08;
    localparam logic [31:0] A_IN     = BASE + 32'h0C;
    localparam logic [31:0] A_OUT    = BASE + 32'h10;
    localparam logic [31:0] A_PARAM  = BASE + 32'h14;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  sb[$];

    always #5 clk = ~clk;

    dataproc_mmio_engine #(
        .BASE_ADDR  (BASE),
        .PIX_W      (8),
        .FIFO_DEPTH (8),
        .CNT_W      (16)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_wstrb (mem_wstrb),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Reference pixel operation
    function automatic logic [7:0] model(input int mode, input int p, input int prm);
        case (mode)
            0:       return 8'(p);
            1:       return 8'(255 - p);
            2:       return (p >= prm) ? 8'hFF : 8'h00;
            default: return (p + prm > 255) ? 8'hFF : 8'(p + prm);
        endcase
    endfunction

    // Reference STATUS word for DEPTH=8
    function automatic logic [31:0] st(input int ic, input int oc, input bit busy,
                                       input bit ovf, input bit udf);
        logic [31:0] s;
        s        = '0;
        s[0]     = (ic == 0);
        s[1]     = (ic == 8);
        s[2]     = (oc == 0);
        s[3]     = (oc == 8);
        s[4]     = busy;
        s[5]     = ovf;
        s[6]     = udf;
        s[15:8]  = 8'(ic);
        s[23:16] = 8'(oc);
        return s;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    // One bus transaction; also checks the single wait-cycle latency
    task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] strb,
                            input logic [31:0] wdata, output logic [31:0] rdata);
        int waited;
        while (mem_ready === 1'b1) begin @(posedge clk); #1; end
        mem_addr  = addr;
        mem_wstrb = strb;
        mem_wdata = wdata;
        mem_valid = 1'b1;
        waited    = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (mem_ready !== 1'b1 && waited < 10);
        rdata     = mem_rdata;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        n_vec++;
        if (mem_ready !== 1'b1 || waited != 1) begin
            n_err++;
            $display("FAIL latency addr=%h actual=%0d cycles required=1", addr, waited);
        end
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        bus_xfer(addr, 4'hF, data, dummy);
    endtask

    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data);
        bus_xfer(addr, 4'h0, 32'h0, data);
    endtask

    task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        bus_rd(addr, rd);
        n_vec++;
        if (rd !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, rd, exp);
        end
    endtask

    task automatic push_pix(input int mode, input int p, input int prm);
        bus_wr(A_IN, 32'(p));
        sb.push_back(model(mode, p, prm));
    endtask

    task automatic pop_check(input string name);
        logic [31:0] rd;
        logic [7:0]  exp;
        bus_rd(A_OUT, rd);
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s scoreboard empty actual=%h", name, rd);
        end else begin
            exp = sb.pop_front();
            if (rd !== {24'h0, exp}) begin
                n_err++;
                $display("FAIL %s actual=%h required=%h", name, rd, {24'h0, exp});
            end
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        idle(3);
        resetn = 1'b1;
        idle(1);
        n_vec++;
        if (mem_ready !== 1'b0 || mem_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs actual=%b/%h required=0/0", mem_ready, mem_rdata);
        end
        rd_check("reset_status", A_STATUS, 32'h0000_0005);
        rd_check("reset_ctrl",   A_CTRL,   32'h0);
        rd_check("reset_pixcnt", A_PIXCNT, 32'h0);
        rd_check("reset_param",  A_PARAM,  32'h0);
    endtask

    task automatic test_invert;
        bus_wr(A_CTRL, 32'h3);
        push_pix(1, 8'h12, 0);
        push_pix(1, 8'h34, 0);
        push_pix(1, 8'h00, 0);
        idle(5);
        for (int i = 0; i < 3; i++) pop_check("invert_out");
        rd_check("invert_pixcnt", A_PIXCNT, 32'd3);
        rd_check("invert_status", A_STATUS, st(0, 0, 0, 0, 0));
    endtask

    task automatic test_thresh_sat;
        bus_wr(A_PARAM, 32'h80);
        rd_check("param_rd", A_PARAM, 32'h80);
        bus_wr(A_CTRL, 32'h5);
        push_pix(2, 8'h7F, 8'h80);
        push_pix(2, 8'h80, 8'h80);
        idle(5);
        pop_check("thresh_lo");
        pop_check("thresh_hi");
        bus_wr(A_CTRL, 32'h7);
        push_pix(3, 8'h90, 8'h80);
        push_pix(3, 8'h10, 8'h80);
        idle(5);
        pop_check("sat_clip");
        pop_check("sat_add");
        rd_check("sat_pixcnt", A_PIXCNT, 32'd7);
        bus_wr(A_PIXCNT, 32'h1234);
        rd_check("pixcnt_wclr", A_PIXCNT, 32'd0);
    endtask

    task automatic test_overflow;
        bus_wr(A_CTRL, 32'h0);
        for (int i = 0; i < 9; i++) begin
            bus_wr(A_IN, 32'(8'hA0 + i));
            if (i < 8) sb.push_back(model(0, 8'hA0 + i, 0));
        end
        rd_check("ovf_status", A_STATUS, st(8, 0, 0, 1, 0));
        bus_wr(A_STATUS, 32'h20);
        rd_check("ovf_w1c", A_STATUS, st(8, 0, 0, 0, 0));
        rd_check("udf_read0", A_OUT, 32'h0);
        rd_check("udf_status", A_STATUS, st(8, 0, 0, 0, 1));
        bus_wr(A_STATUS, 32'h40);
        rd_check("udf_w1c", A_STATUS, st(8, 0, 0, 0, 0));
    endtask

    task automatic test_backpressure;
        bus_wr(A_CTRL, 32'h1);
        idle(20);
        for (int i = 0; i < 3; i++) push_pix(0, 8'hB0 + i, 0);
        idle(10);
        rd_check("bp_status", A_STATUS, st(3, 8, 1, 0, 0));
        rd_check("bp_pixcnt", A_PIXCNT, 32'd8);
        pop_check("bp_out0");
        pop_check("bp_out1");
        idle(10);
        rd_check("bp_status2", A_STATUS, st(1, 8, 1, 0, 0));
        rd_check("bp_pixcnt2", A_PIXCNT, 32'd10);
        bus_wr(A_CTRL, 32'hB);
        sb.delete();
        rd_check("clr_ctrl",   A_CTRL,   32'h3);
        rd_check("clr_status", A_STATUS, st(0, 0, 0, 0, 0));
        rd_check("clr_pixcnt", A_PIXCNT, 32'd0);
    endtask

    task automatic test_latency;
        bus_wr(A_CTRL, 32'h1);
        push_pix(0, 8'h5A, 0);
        // IN accepted at E0, this read latched at E2: stage holds the pixel
        rd_check("lat_stage",  A_STATUS, st(0, 0, 1, 0, 0));
        rd_check("lat_outfifo", A_STATUS, st(0, 1, 0, 0, 0));
        pop_check("lat_out");
    endtask

    task automatic test_back_to_back;
        bus_wr(A_CTRL, 32'h3);
        for (int i = 1; i <= 4; i++) push_pix(1, i, 0);
        idle(6);
        for (int i = 0; i < 4; i++) pop_check("b2b_out");
        rd_check("b2b_pixcnt", A_PIXCNT, 32'd5);
    endtask

    task automatic test_unmapped;
        logic [31:0] addrs [3];
        int          seen;
        addrs[0] = BASE + 32'h18;
        addrs[1] = BASE + 32'h02;
        addrs[2] = BASE - 32'h04;
        for (int a = 0; a < 3; a++) begin
            while (mem_ready === 1'b1) begin @(posedge clk); #1; end
            mem_addr  = addrs[a];
            mem_wstrb = 4'h0;
            mem_valid = 1'b1;
            seen      = 0;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk); #1;
                if (mem_ready !== 1'b0 || mem_rdata !== 32'h0) seen++;
            end
            mem_valid = 1'b0;
            n_vec++;
            if (seen != 0) begin
                n_err++;
                $display("FAIL unmapped addr=%h actual=%0d responses required=0", addrs[a], seen);
            end
        end
    endtask

    task automatic test_reset_mid;
        bus_wr(A_CTRL, 32'h0);
        bus_wr(A_PARAM, 32'h33);
        bus_wr(A_IN, 32'h11);
        while (mem_ready === 1'b1) begin @(posedge clk); #1; end
        mem_addr  = A_IN;
        mem_wstrb = 4'hF;
        mem_wdata = 32'h55;
        mem_valid = 1'b1;
        resetn    = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (mem_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_ready actual=%b required=0", mem_ready);
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        idle(1);
        resetn = 1'b1;
        idle(1);
        sb.delete();
        rd_check("rstmid_status", A_STATUS, 32'h0000_0005);
        rd_check("rstmid_param",  A_PARAM,  32'h0);
        rd_check("rstmid_pixcnt", A_PIXCNT, 32'h0);
    endtask

    initial begin
        resetn    = 1'b0;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        test_reset();
        test_invert();
        test_thresh_sat();
        test_overflow();
        test_backpressure();
        test_latency();
        test_back_to_back();
        test_unmapped();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_dataproc_mmio_engine
`default_nettype wire
